// File: rtl/stm_gain_pkg.sv
// Shared types and lane-extraction helpers for the gain-STM read engine.
package stm_gain_pkg;

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    localparam int unsigned ENTRY_W       = 16;
    localparam int unsigned PHASE_LSB     = 0;
    localparam int unsigned INTENSITY_LSB = 8;
    localparam int unsigned MAX_LANES     = 64;
    localparam int unsigned LANE_SEL_W    = $clog2(MAX_LANES);

    // Widest supported BRAM word; narrower words are zero-extended by the caller.
    typedef logic [ENTRY_W*MAX_LANES-1:0] word_t;

    function automatic logic [7:0] lane_phase(input word_t word,
                                              input logic [LANE_SEL_W-1:0] lane);
        return 8'(word >> (ENTRY_W * lane + PHASE_LSB));
    endfunction

    function automatic logic [7:0] lane_intensity(input word_t word,
                                                  input logic [LANE_SEL_W-1:0] lane);
        return 8'(word >> (ENTRY_W * lane + INTENSITY_LSB));
    endfunction

endpackage

// File: rtl/stm_gain_lane_unpack.sv
// Registered LANES-to-1 mux: picks one packed entry from the word register per cycle.
module stm_gain_lane_unpack
    import stm_gain_pkg::*;
#(
    parameter int unsigned LANES = 4,
    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic [ENTRY_W*LANES-1:0] word,
    input  logic [LANE_W-1:0]        lane,
    input  logic                     valid,
    output logic [7:0]               phase,
    output logic [7:0]               intensity,
    output logic                     dout_valid
);

    word_t word_ext;

    always_comb begin
        word_ext = '0;
        word_ext[ENTRY_W*LANES-1:0] = word;
    end

    // Data registers only load on valid so the last entry is held between frames.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            phase      <= '0;
            intensity  <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= valid;
            if (valid) begin
                phase     <= lane_phase(word_ext, LANE_SEL_W'(lane));
                intensity <= lane_intensity(word_ext, LANE_SEL_W'(lane));
            end
        end
    end

endmodule

// File: rtl/stm_gain_stream.sv
// Gain-STM read engine: walks packed gain BRAM words and streams one
// PHASE/INTENSITY entry per cycle for DEPTH entries after each START.
module stm_gain_stream
    import stm_gain_pkg::*;
#(
    parameter int unsigned DEPTH        = 249,
    parameter int unsigned LANES        = 4,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned IDX_W        = 16,
    localparam int unsigned WORDS  = (DEPTH + LANES - 1) / LANES,
    localparam int unsigned ADDR_W = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     START,
    input  logic                     SEGMENT,
    input  logic [IDX_W-1:0]         IDX,
    output logic                     GAIN_SEGMENT,
    output logic [IDX_W-1:0]         GAIN_IDX,
    output logic [ADDR_W-1:0]        GAIN_ADDR,
    input  logic [ENTRY_W*LANES-1:0] VALUE,
    output logic [7:0]               INTENSITY,
    output logic [7:0]               PHASE,
    output logic                     DOUT_VALID,
    output logic                     BUSY,
    output logic                     DONE
);

    localparam int unsigned LANE_W      = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned PCNT_W      = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam int unsigned ENTRY_CNT_W = $clog2(DEPTH) + 1;

    if (READ_LATENCY < 1 || READ_LATENCY > LANES) begin : g_bad_latency
        $error("stm_gain_stream: READ_LATENCY must lie in 1..LANES");
    end
    if (LANES > MAX_LANES || LANES < 1) begin : g_bad_lanes
        $error("stm_gain_stream: LANES out of range");
    end

    state_t                   state_q;
    logic [PCNT_W-1:0]        prime_q;
    logic [LANE_W-1:0]        lane_q;
    logic [ENTRY_CNT_W-1:0]   entry_q;
    logic [ENTRY_W*LANES-1:0] word_q;
    logic                     seg_q;
    logic [IDX_W-1:0]         idx_q;
    logic [ADDR_W-1:0]        addr_q;
    logic                     busy_q;
    logic                     done_q;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            prime_q <= '0;
            lane_q  <= '0;
            entry_q <= '0;
            word_q  <= '0;
            seg_q   <= 1'b0;
            idx_q   <= '0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    busy_q <= 1'b0;
                    // busy_q is still high in the DONE cycle, so a START there is dropped.
                    if (START && !busy_q) begin
                        idx_q   <= IDX;
                        seg_q   <= SEGMENT;
                        addr_q  <= '0;
                        prime_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= PRIME;
                    end
                end
                PRIME: begin
                    if (prime_q == PCNT_W'(READ_LATENCY - 1)) begin
                        word_q  <= VALUE;
                        lane_q  <= '0;
                        entry_q <= '0;
                        if (WORDS > 1) addr_q <= ADDR_W'(1);
                        state_q <= RUN;
                    end else begin
                        prime_q <= prime_q + 1'b1;
                    end
                end
                RUN: begin
                    // Next word has been on VALUE since the address moved, as latency <= LANES.
                    if (lane_q == LANE_W'(LANES - 1)) begin
                        word_q <= VALUE;
                        lane_q <= '0;
                        if (addr_q != ADDR_W'(WORDS - 1)) addr_q <= addr_q + 1'b1;
                    end else begin
                        lane_q <= lane_q + 1'b1;
                    end
                    if (entry_q == ENTRY_CNT_W'(DEPTH - 1)) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        entry_q <= entry_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    stm_gain_lane_unpack #(
        .LANES(LANES)
    ) u_unpack (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .word      (word_q),
        .lane      (lane_q),
        .valid     (state_q == RUN),
        .phase     (PHASE),
        .intensity (INTENSITY),
        .dout_valid(DOUT_VALID)
    );

    assign GAIN_SEGMENT = seg_q;
    assign GAIN_IDX     = idx_q;
    assign GAIN_ADDR    = addr_q;
    assign BUSY         = busy_q;
    assign DONE         = done_q;

endmodule

// File: doc/stm_gain_stream.md
Name: stm_gain_stream

Overview:
- Parametrised successor gain-STM read engine.
- On START, latches a gain index and a segment, then walks the packed gain BRAM word by word.
- Serialises DEPTH transducer entries, one PHASE/INTENSITY pair per cycle with no bubbles.
- Generalised in lanes per word, BRAM read latency and depth; adds segment select, BUSY/DONE status and a safe partial last word.

Parameters:
- DEPTH, 249, number of transducer entries emitted per START.
- LANES, 4, 16-bit entries packed per BRAM word.
- READ_LATENCY, 2, BRAM address-to-VALUE latency in cycles; elaboration error if 1 > READ_LATENCY or READ_LATENCY > LANES.
- IDX_W, 16, gain index width.
- WORDS, derived, equals ceil(DEPTH/LANES).
- ADDR_W, derived, equals $clog2(WORDS).

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  synchronous active-low reset.
- START  in  1  single-cycle request to emit one gain frame.
- SEGMENT  in  1  segment select, sampled with START.
- IDX  in  IDX_W  gain index, sampled with START.
- GAIN_SEGMENT  out  1  latched segment to BRAM.
- GAIN_IDX  out  IDX_W  latched index to BRAM.
- GAIN_ADDR  out  ADDR_W  word address within the gain.
- VALUE  in  16*LANES  BRAM read data.
- INTENSITY  out  8  entry intensity.
- PHASE  out  8  entry phase.
- DOUT_VALID  out  1  INTENSITY/PHASE valid.
- BUSY  out  1  high from the cycle after START is accepted until the cycle after the last output.
- DONE  out  1  one-cycle pulse coincident with the last valid entry.

Behaviour:
- Reset (RST_N=0 at a CLK edge): state IDLE; all outputs and internal registers 0. Applies identically mid-frame; DOUT_VALID is 0 from the following cycle and no further words are addressed.
- Lane packing: lane j occupies VALUE[16j+15:16j]; phase is [16j+7:16j], intensity is [16j+15:16j+8]. Lane 0 is emitted first.
- States:
  - IDLE: START=1 latches IDX→GAIN_IDX and SEGMENT→GAIN_SEGMENT, sets GAIN_ADDR=0, goes to PRIME.
  - PRIME: waits READ_LATENCY cycles, then captures VALUE into the word register, advances GAIN_ADDR to 1 (if WORDS>1) and goes to RUN.
  - RUN: emits one lane per cycle from the word register.
    - At lane LANES-1, captures VALUE (the next word, valid because READ_LATENCY ≤ LANES and the address is held) and advances GAIN_ADDR.
    - GAIN_ADDR saturates at WORDS-1 and is never driven beyond it.
    - After the DEPTH-th entry, goes to IDLE.
- Latency: START sampled at edge 0 → first DOUT_VALID=1 in cycle READ_LATENCY+2; DOUT_VALID then stays high for exactly DEPTH consecutive cycles.
- Partial last word: when DEPTH mod LANES ≠ 0, the unused trailing lanes are never emitted.
- START while BUSY is ignored; GAIN_IDX and GAIN_SEGMENT stay stable for the whole frame.
- START in the same cycle as DONE is ignored; it is accepted only in IDLE.
- Outputs are registered. INTENSITY/PHASE hold their last value when DOUT_VALID=0.
- Counters: lane counter is $clog2(LANES) bits and wraps. Entry counter is $clog2(DEPTH)+1 bits; terminal compare is against DEPTH-1.

Decomposition:
- Shared package stm_gain_pkg holds:
  - state_t enum {IDLE, PRIME, RUN};
  - localparams ENTRY_W=16, PHASE_LSB=0, INTENSITY_LSB=8;
  - function lane_phase(word, lane) and function lane_intensity(word, lane).
- One natural sub-module: stm_gain_lane_unpack. It is a registered LANES-to-1 mux producing PHASE, INTENSITY and DOUT_VALID from the word register, lane index and a valid flag.

Test Plan:
- DEPTH=249, LANES=4, RL=2; BRAM model word w = {lanes 16'h(w*4+j)}; START with IDX=5, SEG=1 → first valid at cycle 4; 249 consecutive valid cycles; entry k has PHASE=k[7:0] and INTENSITY=k[15:8]; GAIN_ADDR covers 0..62 only; DONE on entry 248.
- Same configuration with START re-pulsed at entries 10 and 248 → ignored; GAIN_IDX stays 5 throughout; exactly 249 outputs.
- RST_N=0 at entry 100 → DOUT_VALID=0 and BUSY=0 the next cycle, all outputs 0; a new START then gives a full 249-entry frame.
- LANES=8, RL=8, DEPTH=16 → 16 bubble-free outputs; addresses 0 and 1 only; first valid at cycle 10.
- DEPTH=5, LANES=4 → lanes 0..3 of word 0 then lane 0 of word 1; GAIN_ADDR never reaches 2.
- START and SEGMENT changing every cycle while BUSY → GAIN_SEGMENT constant at the value captured with the accepted START.
